fft_bitrev_reorder: RTL and testbench

//  Output-side reorder stage for the SDF FFT pipeline. Accepts one complex sample per cycle in
//  bit-reversed order, as produced by the last delay-feedback butterfly stage. Presents the same

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_reorder_ram.sv | 29 ++
 rtl/fft_bitrev_reorder.sv | 202 ++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output reorder stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam int N     = 128;
    localparam int LOG2N = 7;
    localparam int WIDTH = 14;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Mirror the address bits: bit i <-> bit LOG2N-1-i.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame RAM, address = {bank, index}; one write and one read port.
// Latency: read data registered, valid 1 clk after a read-enabled cycle.
// Backpressure: none; rdata holds while re is low.
module fft_reorder_ram #(
    parameter int AW = 8,
    parameter int DW = 28
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port and registered read port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder via two ping-pong banks; optional out_first/out_last via FFT_REORDER_FRAME_MARKERS_EN.
// Latency: last input handshake of a frame at t -> sample 0 on the output at t+2.
// Backpressure: reads stop when the 2-entry skid is committed; input stalls only when both banks are full.
module fft_bitrev_reorder #(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [fft_pkg::WIDTH-1:0] in_re,
    input  logic [fft_pkg::WIDTH-1:0] in_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [fft_pkg::WIDTH-1:0] out_re,
    output logic [fft_pkg::WIDTH-1:0] out_im
`ifdef FFT_REORDER_FRAME_MARKERS_EN
    ,
    output logic                      out_first,
    output logic                      out_last
`endif
);
    import fft_pkg::*;

    logic [1:0]       full, full_nxt;
    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_addr;
    logic             wr_en, wr_done, rd_active, rd_en, rd_done;
    rd_state_t        state, state_nxt;
    cplx_t            in_dat, ram_q;
    logic             rd_pend;
    logic [1:0]       sk_cnt, sk_pos;
    cplx_t            sk_dat [2];
    logic             pop, sk_pop, sk_push;
    logic [2:0]       occ_after;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
    logic             q_first, q_last;
    logic [1:0]       sk_first, sk_last;
`endif

    // ---------------- write side ----------------
    assign in_ready = !full[wr_bank];
    assign wr_en    = in_valid && in_ready;
    assign wr_done  = wr_en && (wr_cnt == LOG2N'(N-1));
    assign in_dat   = {in_re, in_im};

    // Package helper covers the production size; reduced-size builds mirror locally.
    if (LOG2N == fft_pkg::LOG2N) begin : g_pkg_rev
        assign wr_addr = bitrev(wr_cnt);
    end else begin : g_loc_rev
        // Mirror write counter bits to form the bit-reversed store address.
        always_comb begin
            wr_addr = '0;
            for (int i = 0; i < LOG2N; i++) begin
                wr_addr[i] = wr_cnt[LOG2N-1-i];
            end
        end
    end

    // ---------------- read side ----------------
    // occ_after: samples committed to the output after this cycle's pop; never exceeds skid depth.
    assign out_valid = (sk_cnt != 2'd0) || rd_pend;
    assign pop       = out_valid && out_ready;
    assign sk_pop    = pop && (sk_cnt != 2'd0);
    assign sk_push   = rd_pend && !(pop && (sk_cnt == 2'd0));
    assign sk_pos    = sk_cnt - {1'b0, sk_pop};
    assign occ_after = {1'b0, sk_cnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign rd_active = (state == RD_STREAM) || full[rd_bank];
    assign rd_en     = rd_active && (occ_after < 3'd2);
    assign rd_done   = rd_en && (rd_cnt == LOG2N'(N-1));

    fft_reorder_ram #(
        .AW(LOG2N + 1),
        .DW(2 * WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr({wr_bank, wr_addr}),
        .wdata(in_dat),
        .re   (rd_en),
        .raddr({rd_bank, rd_cnt}),
        .rdata(ram_q)
    );

    // Bank flags: fill and drain always target different banks, so both may update together.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    // Read FSM next state; at frame end continue straight into the other bank if it is ready.
    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:   if (full[rd_bank]) state_nxt = RD_STREAM;
            RD_STREAM: if (rd_done) state_nxt = full_nxt[!rd_bank] ? RD_STREAM : RD_IDLE;
            default:   state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RD_IDLE;
        else        state <= state_nxt;
    end

    // Bank flags, write counter and write bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
                if (wr_done) wr_bank <= !wr_bank;
            end
        end
    end

    // Natural-order read counter, read bank pointer and RAM output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
                if (rd_done) rd_bank <= !rd_bank;
            end
        end
    end

    // Skid buffer: RAM data not consumed directly is parked behind older entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_cnt    <= 2'd0;
            sk_dat[0] <= '0;
            sk_dat[1] <= '0;
        end else begin
            sk_cnt <= sk_cnt - {1'b0, sk_pop} + {1'b0, sk_push};
            if (sk_pop) sk_dat[0] <= sk_dat[1];
            if (sk_push) sk_dat[sk_pos[0]] <= ram_q;
        end
    end

`ifdef FFT_REORDER_FRAME_MARKERS_EN
    // Frame markers follow the same path as the data: tagged at read issue, then skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_first  <= 1'b0;
            q_last   <= 1'b0;
            sk_first <= 2'b00;
            sk_last  <= 2'b00;
        end else begin
            if (rd_en) begin
                q_first <= (rd_cnt == '0);
                q_last  <= (rd_cnt == LOG2N'(N-1));
            end
            if (sk_pop) begin
                sk_first[0] <= sk_first[1];
                sk_last[0]  <= sk_last[1];
            end
            if (sk_push) begin
                sk_first[sk_pos[0]] <= q_first;
                sk_last[sk_pos[0]]  <= q_last;
            end
        end
    end
`endif

    // Output mux: oldest skid entry first, else RAM data; zero while nothing is valid.
    always_comb begin
        out_re = '0;
        out_im = '0;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
        out_first = 1'b0;
        out_last  = 1'b0;
`endif
        if (sk_cnt != 2'd0) begin
            out_re = sk_dat[0].re;
            out_im = sk_dat[0].im;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
            out_first = sk_first[0];
            out_last  = sk_last[0];
`endif
        end else if (rd_pend) begin
            out_re = ram_q.re;
            out_im = ram_q.im;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
            out_first = q_first;
            out_last  = q_last;
`endif
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder at N=8: vector table for the first frame, then scoreboarded sequences.
// Latency: checks the t+2 first-output latency explicitly.
// Backpressure: exercises full stall, random stall and toggling out_ready.
module tb_fft_bitrev_reorder;

    localparam int NN = 8;
    localparam int W  = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
    logic         out_first;
    logic         out_last;
    logic         prev_first, prev_last;
`endif

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N(NN), .LOG2N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im)
`ifdef FFT_REORDER_FRAME_MARKERS_EN
        ,
        .out_first(out_first),
        .out_last (out_last)
`endif
    );

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } samp_t;

    typedef struct {
        logic [W-1:0] in_re;
        logic [W-1:0] in_im;
        logic [W-1:0] exp_re;
        logic [W-1:0] exp_im;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     epoch    = 0;
    int     drv_h    = 0;
    int     mon_in   = 0;
    int     mon_out  = 0;
    int     in_stall = 0;
    int     out_seen = 0;
    int     gaps     = 0;
    int     gap_tgt  = 0;
    bit     sb_on    = 1'b0;
    bit     prev_stall;
    logic [W-1:0] prev_re, prev_im;
    samp_t  exp_q[$];
    vec_t   tv[NN];

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic logic [W-1:0] val_re(input int ep, input int f, input int j);
        return W'(ep * 1000 + f * 37 + j * 5 + 3);
    endfunction

    function automatic logic [W-1:0] val_im(input int ep, input int f, input int j);
        return W'((ep * 777) ^ (f * 91) ^ (j * 13) ^ 341);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected natural-order frame queued on its last input handshake.
    always @(negedge clk) begin
        if (!rst_n || !sb_on) begin
            exp_q.delete();
            mon_in     = 0;
            mon_out    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", int'(out_valid), 1);
                check("hold_re", int'(out_re), int'(prev_re));
                check("hold_im", int'(out_im), int'(prev_im));
`ifdef FFT_REORDER_FRAME_MARKERS_EN
                check("hold_first", int'(out_first), int'(prev_first));
                check("hold_last", int'(out_last), int'(prev_last));
`endif
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got re=%0d with nothing expected", out_re);
                end else begin
                    samp_t e;
                    e = exp_q.pop_front();
                    check("sb_re", int'(out_re), int'(e.re));
                    check("sb_im", int'(out_im), int'(e.im));
                end
`ifdef FFT_REORDER_FRAME_MARKERS_EN
                check("mk_first", int'(out_first), int'((mon_out % NN) == 0));
                check("mk_last", int'(out_last), int'((mon_out % NN) == NN - 1));
`endif
                mon_out++;
            end
            if (in_valid && in_ready) begin
                if ((mon_in % NN) == NN - 1) begin
                    for (int j = 0; j < NN; j++) begin
                        exp_q.push_back({val_re(epoch, mon_in / NN, j), val_im(epoch, mon_in / NN, j)});
                    end
                end
                mon_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_re;
            prev_im    = out_im;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
            prev_first = out_first;
            prev_last  = out_last;
`endif
        end
    end

    task automatic drive_data();
        in_re = val_re(epoch, drv_h / NN, rev3(drv_h % NN));
        in_im = val_im(epoch, drv_h / NN, rev3(drv_h % NN));
    endtask

    // One cycle per iteration; pin/pout are percent probabilities of in_valid/out_ready.
    task automatic run(input int cycles, input int limit, input int pin, input int pout);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = (drv_h < limit) && (int'($urandom_range(0, 99)) < pin);
            drive_data();
            out_ready = (int'($urandom_range(0, 99)) < pout);
            @(negedge clk);
            if (in_valid && !in_ready) in_stall++;
            if (out_valid) out_seen++;
            else if (out_seen > 0 && out_seen < gap_tgt) gaps++;
            if (in_valid && in_ready) drv_h++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drv_h     = 0;
        in_stall  = 0;
        out_seen  = 0;
        gaps      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rst_in_ready"}, int'(in_ready), 1);
        check({tag, "_rst_out_valid"}, int'(out_valid), 0);
        check({tag, "_rst_out_re"}, int'(out_re), 0);
        check({tag, "_rst_out_im"}, int'(out_im), 0);
`ifdef FFT_REORDER_FRAME_MARKERS_EN
        check({tag, "_rst_first"}, int'(out_first), 0);
        check({tag, "_rst_last"}, int'(out_last), 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Slot order input ramp 0,4,2,6,1,5,3,7 (im = re + 100); natural order expected out.
        tv[0] = '{14'd0, 14'd100, 14'd0, 14'd100};
        tv[1] = '{14'd4, 14'd104, 14'd1, 14'd101};
        tv[2] = '{14'd2, 14'd102, 14'd2, 14'd102};
        tv[3] = '{14'd6, 14'd106, 14'd3, 14'd103};
        tv[4] = '{14'd1, 14'd101, 14'd4, 14'd104};
        tv[5] = '{14'd5, 14'd105, 14'd5, 14'd105};
        tv[6] = '{14'd3, 14'd103, 14'd6, 14'd106};
        tv[7] = '{14'd7, 14'd107, 14'd7, 14'd107};

        // Test 1: single frame from the vector table, latency and order.
        do_reset();
        reset_checks("t1");
        for (int k = 0; k < NN; k++) begin
            in_valid  = 1'b1;
            in_re     = tv[k].in_re;
            in_im     = tv[k].in_im;
            out_ready = 1'b1;
            @(negedge clk);
            check("t1_in_ready", int'(in_ready), 1);
            check("t1_no_out", int'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat_t+1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            check("t1_vld", int'(out_valid), 1);
            check("t1_re", int'(out_re), int'(tv[k].exp_re));
            check("t1_im", int'(out_im), int'(tv[k].exp_im));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t1_drained", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // Test 2: four back-to-back frames at full rate.
        do_reset();
        sb_on   = 1'b1;
        epoch   = 2;
        gap_tgt = 4 * NN;
        run(60, 4 * NN, 100, 100);
        check("t2_in_stalls", in_stall, 0);
        check("t2_out_gaps", gaps, 0);
        check("t2_out_cnt", out_seen, 4 * NN);
        check("t2_sb_out", mon_out, 4 * NN);
        check("t2_sb_left", exp_q.size(), 0);

        // Test 3: output stalled for 3N cycles while input streams, then released.
        do_reset();
        epoch = 3;
        run(3 * NN, 4 * NN, 100, 0);
        check("t3_accepted", drv_h, 2 * NN);
        check("t3_in_stalls", in_stall, NN);
        check("t3_in_ready", int'(in_ready), 0);
        check("t3_out_valid", int'(out_valid), 1);
        check("t3_out_re", int'(out_re), int'(val_re(3, 0, 0)));
        run(60, 4 * NN, 100, 100);
        check("t3_accepted_all", drv_h, 4 * NN);
        check("t3_sb_out", mon_out, 4 * NN);
        check("t3_sb_left", exp_q.size(), 0);

        // Test 4: random in_valid/out_ready over 20 frames.
        do_reset();
        epoch = 4;
        for (int i = 0; i < 4000 && mon_out < 20 * NN; i++) run(1, 20 * NN, 50, 50);
        check("t4_in_hs", mon_in, 20 * NN);
        check("t4_out_hs", mon_out, 20 * NN);
        check("t4_sb_left", exp_q.size(), 0);

        // Test 5: reset at input sample 5 of frame 2 while frame 1 is draining.
        do_reset();
        epoch = 5;
        for (int i = 0; i < 100 && drv_h < 2 * NN + 5; i++) run(1, 8 * NN, 100, 100);
        check("t5_at_sample", drv_h, 2 * NN + 5);
        check("t5_pre_vld", int'(out_valid), 1);
        in_valid = 1'b1;
        drive_data();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_in_ready", int'(in_ready), 1);
        check("t5_rst_out_re", int'(out_re), 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        epoch = 6;
        drv_h = 0;
        @(posedge clk);
        #1;
        run(50, 2 * NN, 100, 100);
        check("t5_accepted", drv_h, 2 * NN);
        check("t5_sb_out", mon_out, 2 * NN);
        check("t5_sb_left", exp_q.size(), 0);

        // Test 6: out_ready toggling over three frames (markers checked by the scoreboard).
        do_reset();
        epoch = 7;
        for (int i = 0; i < 200 && mon_out < 3 * NN; i++) run(1, 3 * NN, 100, (i % 3 == 0) ? 0 : 100);
        check("t6_sb_out", mon_out, 3 * NN);
        check("t6_sb_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
